// File: rtl/ack_req_if.sv
// Ack-bus side signals of one per-source requester.
// master: the requester; slave: the module/bus side that feeds it.
interface ack_req_if;
  logic       ack_push;
  logic       ack_ready;
  logic       ack_event;
  logic       clr_overflow;
  logic       req;
  logic       ack_done;
  logic [3:0] pending;
  logic       overflow;
  logic       starved;

  modport master (
    input  ack_push, ack_ready, ack_event, clr_overflow,
    output req, ack_done, pending, overflow, starved
  );

  modport slave (
    output ack_push, ack_ready, ack_event, clr_overflow,
    input  req, ack_done, pending, overflow, starved
  );
endinterface

// File: rtl/ack_req_agent.sv
// Per-source ack requester: queues completion events, requests the fixed-priority
// ack bus, backs off after each grant, and flags overflow and starvation.
module ack_req_agent #(
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned HOLDOFF      = 1,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  ack_req_if.master bus
);

  localparam int unsigned PEND_W = 4;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                req_q, req_d;
  logic                ack_done_q, ack_done_d;
  logic                overflow_q, overflow_d;
  logic                starved_q, starved_d;

  logic                grant;
  logic                at_max;
  logic                drop;
  logic                has_work;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    hold_cnt_d = hold_cnt_q;
    wait_d     = '0;
    overflow_d = overflow_q;

    grant    = (state_q == S_REQ) && bus.ack_ready && bus.ack_event;
    at_max   = (pending_q == PEND_W'(MAX_PENDING));
    drop     = bus.ack_push && !grant && at_max;
    has_work = (pending_q != '0) || bus.ack_push;

    // Push and grant together cancel; a push at the ceiling without a grant is lost.
    if (bus.ack_push && !grant && !at_max) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (grant && !bus.ack_push) begin
      pending_d = pending_q - PEND_W'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (has_work) state_d = S_REQ;
      end
      S_REQ: begin
        if (grant) begin
          if (HOLDOFF != 0) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_W'(HOLDOFF - 1);
          end else begin
            state_d = (pending_d != '0) ? S_REQ : S_IDLE;
          end
        end else begin
          wait_d = (wait_q == WAIT_W'(STARVE_LIMIT)) ? wait_q : wait_q + WAIT_W'(1);
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = has_work ? S_REQ : S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d      = (state_d == S_REQ);
    ack_done_d = grant;
    starved_d  = (wait_d == WAIT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      hold_cnt_q <= '0;
      wait_q     <= '0;
      req_q      <= 1'b0;
      ack_done_q <= 1'b0;
      overflow_q <= 1'b0;
      starved_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      hold_cnt_q <= hold_cnt_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      ack_done_q <= ack_done_d;
      overflow_q <= overflow_d;
      starved_q  <= starved_d;
    end
  end

  assign bus.req      = req_q;
  assign bus.ack_done = ack_done_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.starved  = starved_q;

endmodule
